// File: rtl/ibuffer_warp_fifo_if.sv
// Decode-to-instruction-buffer bundle: two decode lanes in, per-warp head/back-pressure out.
// master = decode/fetch/issue side, slave = the instruction buffer.
interface ibuffer_warp_fifo_if #(
    parameter int NWARP = 8
);
    logic [NWARP-1:0]    Valid_IF_ID0_IB;
    logic [NWARP-1:0]    Valid_IF_ID1_IB;
    logic [31:0]         Instr_ID0_IB;
    logic [31:0]         Instr_ID1_IB;
    logic [4:0]          Dst_ID0_IB;
    logic [4:0]          Dst_ID1_IB;
    logic [14:0]         Ctrl_ID0_IB;
    logic [14:0]         Ctrl_ID1_IB;
    logic [NWARP-1:0]    Flush_IB;
    logic [NWARP-1:0]    Grant_IB;
    logic [NWARP-1:0]    Head_Valid_IB;
    logic [NWARP*52-1:0] Head_Data_IB;
    logic [NWARP-1:0]    Full_IB_IF;
    logic                Overflow_IB;

    modport master (
        output Valid_IF_ID0_IB, Valid_IF_ID1_IB, Instr_ID0_IB, Instr_ID1_IB,
               Dst_ID0_IB, Dst_ID1_IB, Ctrl_ID0_IB, Ctrl_ID1_IB, Flush_IB, Grant_IB,
        input  Head_Valid_IB, Head_Data_IB, Full_IB_IF, Overflow_IB
    );

    modport slave (
        input  Valid_IF_ID0_IB, Valid_IF_ID1_IB, Instr_ID0_IB, Instr_ID1_IB,
               Dst_ID0_IB, Dst_ID1_IB, Ctrl_ID0_IB, Ctrl_ID1_IB, Flush_IB, Grant_IB,
        output Head_Valid_IB, Head_Data_IB, Full_IB_IF, Overflow_IB
    );
endinterface

// File: rtl/ibuffer_warp_fifo.sv
// Eight independent per-warp instruction FIFOs fed by two decode lanes (ID0 older than ID1).
// Optional IB_BYPASS_EN: an empty warp presents its incoming entry combinationally.
module ibuffer_warp_fifo #(
    parameter int DEPTH = 4,
    parameter int NWARP = 8
) (
    input logic           clk,
    input logic           rst,
    ibuffer_warp_fifo_if.slave ib
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  dst;
        logic [14:0] ctrl;
    } ib_entry_t;

    ib_entry_t ent0, ent1;
    logic      noop0, noop1;
    logic [NWARP-1:0]    drop;
    logic [NWARP-1:0]    head_vld;
    logic [NWARP-1:0]    full;
    logic [NWARP*52-1:0] head_dat;
    logic                overflow;

    assign ent0  = '{instr: ib.Instr_ID0_IB, dst: ib.Dst_ID0_IB, ctrl: ib.Ctrl_ID0_IB};
    assign ent1  = '{instr: ib.Instr_ID1_IB, dst: ib.Dst_ID1_IB, ctrl: ib.Ctrl_ID1_IB};
    assign noop0 = ib.Ctrl_ID0_IB[4];
    assign noop1 = ib.Ctrl_ID1_IB[4];

    genvar w;
    for (w = 0; w < NWARP; w++) begin : g_warp
        ib_entry_t     mem [DEPTH];
        logic [PW-1:0] rptr, wptr;
        logic [CW-1:0] cnt;
        logic          wr0, wr1, acc0, acc1, st0, st1, pop, empty;

        assign wr0   = ib.Valid_IF_ID0_IB[w] && !noop0;
        assign wr1   = ib.Valid_IF_ID1_IB[w] && !noop1;
        assign empty = (cnt == '0);

        // Space is judged on the pre-cycle count; ID1 needs a second slot only when ID0 also lands here.
        assign acc0 = wr0 && (cnt < CW'(DEPTH));
        assign acc1 = wr1 && (wr0 ? (cnt < CW'(DEPTH - 1)) : (cnt < CW'(DEPTH)));
        assign drop[w] = !ib.Flush_IB[w] && ((wr0 && !acc0) || (wr1 && !acc1));
        assign pop  = ib.Grant_IB[w] && !empty;

`ifdef IB_BYPASS_EN
        logic byp_vld, byp_take;
        assign byp_vld  = empty && (wr0 || wr1) && !ib.Flush_IB[w] && !rst;
        assign byp_take = byp_vld && ib.Grant_IB[w];
        // A granted bypass entry is the oldest incoming one and is never stored.
        assign st0 = acc0 && !byp_take;
        assign st1 = acc1 && !(byp_take && !wr0);
        assign head_vld[w] = !empty || byp_vld;
        assign head_dat[52*w +: 52] = empty ? (wr0 ? ent0 : ent1) : mem[rptr];
`else
        assign st0 = acc0;
        assign st1 = acc1;
        assign head_vld[w] = !empty;
        assign head_dat[52*w +: 52] = mem[rptr];
`endif

        assign full[w] = (cnt >= CW'(DEPTH - 1));

        always_ff @(posedge clk) begin
            if (rst || ib.Flush_IB[w]) begin
                rptr <= '0;
                wptr <= '0;
                cnt  <= '0;
            end else begin
                wptr <= wptr + PW'(st0) + PW'(st1);
                rptr <= rptr + PW'(pop);
                cnt  <= cnt + CW'(st0) + CW'(st1) - CW'(pop);
            end
        end

        always_ff @(posedge clk) begin
            if (!rst && !ib.Flush_IB[w]) begin
                if (st0) mem[wptr] <= ent0;
                if (st1) mem[wptr + PW'(st0)] <= ent1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)        overflow <= 1'b0;
        else if (|drop) overflow <= 1'b1;
    end

    assign ib.Head_Valid_IB = head_vld;
    assign ib.Head_Data_IB  = head_dat;
    assign ib.Full_IB_IF    = full;
    assign ib.Overflow_IB   = overflow;
endmodule
